// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, multi-cycle state encoding and datapath select codes.
// Used by the multi-cycle sequencer as well as Control and ALUcontrol.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12,
        ST_HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Pure state-to-control-vector lookup for the multi-cycle sequencer.
// The handshake-dependent terms (FETCH PC/IR load, MEMWR retire) are added by the top.
module mc_out_decode
    import mips_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEMADR, ST_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.retire     = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.retire    = 1'b1;
            end
            ST_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.retire    = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.retire        = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.retire    = 1'b1;
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: Moore FSM stepping fetch/decode/execute/memory/write-back,
// with memory-ready stalls, illegal-opcode detection and a retired-instruction counter.
//
// state  | meaning
// IDLE   | after reset, one cycle before the first fetch
// FETCH  | read instruction at PC, load IR and PC+4 when memory is ready
// DECODE | read registers, precompute branch target, dispatch on opcode
// MEMADR | compute load/store address
// MEMRD  | load data read, waits on memory
// MEMWB  | load data written to register file
// MEMWR  | store data write, waits on memory
// EXEC   | R-type ALU operation
// RWB    | R-type result written back
// BRANCH | beq compare and conditional PC load
// JUMP   | jump target loaded into PC
// ADDIEX | addi ALU operation
// ADDIWB | addi result written back
// HALT   | stopped on an illegal opcode until reset
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int COUNT_W         = 32
) (
    input  logic               clk,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [3:0]         state,
    output logic               retired,
    output logic               illegal_op,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);
    import mips_pkg::*;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_illegal;
    logic                 w_in_fetch;
    logic                 w_retire;
    ctrl_t                w_ctrl;
    logic [COUNT_W-1:0]   r_count;

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH:  if (mem_ready) w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_RTYPE:     w_next_state = ST_EXEC;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
                    OP_ADDI:      w_next_state = ST_ADDIEX;
                    default: begin
                        w_illegal = 1'b1;
                        if (HALT_ON_ILLEGAL) w_next_state = ST_HALT;
                        else                 w_next_state = ST_FETCH;
                    end
                endcase
            end
            // opcode is held stable from IR load, so only sw needs distinguishing here
            ST_MEMADR: w_next_state = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready) w_next_state = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) w_next_state = ST_FETCH;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB:
                       w_next_state = ST_FETCH;
            ST_EXEC:   w_next_state = ST_RWB;
            ST_ADDIEX: w_next_state = ST_ADDIWB;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    mc_out_decode u_out_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign w_in_fetch = (r_state == ST_FETCH);
    assign w_retire   = w_ctrl.retire | ((r_state == ST_MEMWR) & mem_ready);

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign PCWrite     = w_ctrl.pc_write | (w_in_fetch & mem_ready);
    assign IRWrite     = w_ctrl.ir_write | (w_in_fetch & mem_ready);
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign state       = r_state;
    assign retired     = w_retire;
    assign illegal_op  = w_illegal;
    assign halted      = w_ctrl.halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference traces,
// one instance halting on illegal opcodes (32-bit count), one treating them as NOP (4-bit count).
module tb_multicycle_control;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                   S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_BRANCH = 9,
                   S_JUMP = 10, S_ADDIEX = 11, S_ADDIWB = 12, S_HALT = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       start_a, start_b, mem_ready;
    logic [5:0] opcode;

    logic        pcw_a, pcc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, sa_a;
    logic [1:0]  sb_a, aop_a, psrc_a;
    logic [3:0]  state_a;
    logic        ret_a, ill_a, hlt_a;
    logic [31:0] cnt_a;

    logic        pcw_b, pcc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, sa_b;
    logic [1:0]  sb_b, aop_b, psrc_b;
    logic [3:0]  state_b;
    logic        ret_b, ill_b, hlt_b;
    logic [3:0]  cnt_b;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1), .COUNT_W(32)) u_a (
        .clk(clk), .start(start_a), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .PCWriteCond(pcc_a), .IorD(iord_a), .MemRead(mrd_a),
        .MemWrite(mwr_a), .IRWrite(irw_a), .MemtoReg(m2r_a), .RegDst(rdst_a),
        .RegWrite(rw_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(aop_a),
        .PCSource(psrc_a), .state(state_a), .retired(ret_a), .illegal_op(ill_a),
        .halted(hlt_a), .instr_count(cnt_a)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0), .COUNT_W(4)) u_b (
        .clk(clk), .start(start_b), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .PCWriteCond(pcc_b), .IorD(iord_b), .MemRead(mrd_b),
        .MemWrite(mwr_b), .IRWrite(irw_b), .MemtoReg(m2r_b), .RegDst(rdst_b),
        .RegWrite(rw_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(aop_b),
        .PCSource(psrc_b), .state(state_b), .retired(ret_b), .illegal_op(ill_b),
        .halted(hlt_b), .instr_count(cnt_b)
    );

    logic        sel;
    logic [18:0] obs_vec;
    logic [3:0]  obs_state;
    logic [31:0] obs_cnt;

    always_comb begin
        if (sel) begin
            obs_vec   = {pcw_b, pcc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, sa_b,
                         sb_b, aop_b, psrc_b, ret_b, ill_b, hlt_b};
            obs_state = state_b;
            obs_cnt   = {28'b0, cnt_b};
        end else begin
            obs_vec   = {pcw_a, pcc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, sa_a,
                         sb_a, aop_a, psrc_a, ret_a, ill_a, hlt_a};
            obs_state = state_a;
            obs_cnt   = cnt_a;
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cnt_model;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    // Expected control outputs straight from the per-state output table.
    function automatic logic [18:0] exp_vec(input int st, input logic mr, input logic [5:0] op);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ret, ill, hlt;
        logic [1:0] sb, aop, psrc;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ret, ill, hlt} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
            S_DECODE: begin sb = 2'b11; ill = !legal(op); end
            S_MEMADR, S_ADDIEX: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iord = 1; end
            S_MEMWR:  begin mwr = 1; iord = 1; ret = mr; end
            S_MEMWB:  begin rw = 1; m2r = 1; ret = 1; end
            S_EXEC:   begin sa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rdst = 1; ret = 1; end
            S_ADDIWB: begin rw = 1; ret = 1; end
            S_BRANCH: begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; ret = 1; end
            S_JUMP:   begin pcw = 1; psrc = 2'b10; ret = 1; end
            S_HALT:   hlt = 1;
            default:  ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc, ret, ill, hlt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int st, input logic mr, input logic [5:0] op);
        logic [18:0] ev;
        @(negedge clk);
        mem_ready = mr;
        opcode    = op;
        #1;
        ev = exp_vec(st, mr, op);
        check($sformatf("state@s%0d", st), {28'b0, obs_state}, 32'(st));
        check($sformatf("ctrl@s%0d", st), {13'b0, obs_vec}, {13'b0, ev});
        check($sformatf("count@s%0d", st), obs_cnt, cnt_model);
        if (ev[2]) cnt_model = (cnt_model + 1) & (sel ? 32'hF : 32'hFFFF_FFFF);
    endtask

    task automatic reset_dut();
        if (sel) start_b = 1'b0; else start_a = 1'b0;
        #1;
        check("rst_state", {28'b0, obs_state}, 32'd0);
        check("rst_ctrl", {13'b0, obs_vec}, 32'd0);
        check("rst_count", obs_cnt, 32'd0);
        cnt_model = 0;
        @(negedge clk);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        mem_ready = rbit();
        #1;
        check("idle_state", {28'b0, obs_state}, 32'd0);
        check("idle_ctrl", {13'b0, obs_vec}, 32'd0);
    endtask

    // Expected cycle trace for one instruction, with fs fetch stalls and ms memory stalls.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        for (int i = 0; i < fs; i++) cyc(S_FETCH, 1'b0, op);
        cyc(S_FETCH, 1'b1, op);
        cyc(S_DECODE, rbit(), op);
        case (op)
            6'h23: begin
                cyc(S_MEMADR, rbit(), op);
                for (int i = 0; i < ms; i++) cyc(S_MEMRD, 1'b0, op);
                cyc(S_MEMRD, 1'b1, op);
                cyc(S_MEMWB, rbit(), op);
            end
            6'h2B: begin
                cyc(S_MEMADR, rbit(), op);
                for (int i = 0; i < ms; i++) cyc(S_MEMWR, 1'b0, op);
                cyc(S_MEMWR, 1'b1, op);
            end
            6'h00: begin cyc(S_EXEC, rbit(), op); cyc(S_RWB, rbit(), op); end
            6'h04: cyc(S_BRANCH, rbit(), op);
            6'h02: cyc(S_JUMP, rbit(), op);
            6'h08: begin cyc(S_ADDIEX, rbit(), op); cyc(S_ADDIWB, rbit(), op); end
            default: ;
        endcase
    endtask

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        sel = 1'b0; start_a = 1'b0; start_b = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
        cnt_model = 0;
        #12;

        // Instance A: halts on illegal opcodes, 32-bit count
        reset_dut();
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 2);
        run_instr(6'h04, 0, 0);
        run_instr(6'h2B, 1, 1);
        run_instr(6'h08, 2, 0);
        run_instr(6'h02, 0, 0);
        for (int n = 0; n < 40; n++)
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset in the middle of a store write
        cyc(S_FETCH, 1'b1, 6'h2B);
        cyc(S_DECODE, 1'b1, 6'h2B);
        cyc(S_MEMADR, 1'b1, 6'h2B);
        cyc(S_MEMWR, 1'b0, 6'h2B);
        start_a = 1'b0;
        #1;
        check("abort_state", {28'b0, obs_state}, 32'd0);
        check("abort_memwrite", {31'b0, mwr_a}, 32'd0);
        check("abort_count", obs_cnt, 32'd0);
        reset_dut();
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 1, 0);

        // Illegal opcode halts until reset
        cyc(S_FETCH, 1'b1, 6'h3F);
        cyc(S_DECODE, rbit(), 6'h3F);
        for (int n = 0; n < 12; n++) cyc(S_HALT, rbit(), 6'($urandom_range(0, 63)));
        start_a = 1'b0;

        // Instance B: illegal is a NOP, 4-bit wrapping count
        sel = 1'b1;
        reset_dut();
        run_instr(6'h3F, 0, 0);
        for (int n = 0; n < 16; n++) run_instr(6'h02, $urandom_range(0, 1), 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h15, 1, 0);
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0) run_instr(6'h3F, $urandom_range(0, 1), 0);
            else run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
